// File: rtl/prbs_pkg.sv
// Shared constants for the parameterised PRBS generator: mode codes, LFSR degree/tap tables, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prbs_pkg;

    // Full LFSR register width; shorter polynomials use the low bits only.
    localparam int LFSR_W = 31;

    // Polynomial select codes; codes 5..7 alias PRBS31.
    localparam logic [2:0] MODE_PRBS7  = 3'd0;
    localparam logic [2:0] MODE_PRBS9  = 3'd1;
    localparam logic [2:0] MODE_PRBS15 = 3'd2;
    localparam logic [2:0] MODE_PRBS23 = 3'd3;
    localparam logic [2:0] MODE_PRBS31 = 3'd4;

    // Degree L and middle tap exponent T per polynomial, index 0 = PRBS7 ... 4 = PRBS31.
    localparam logic [4:0][4:0] DEG_TAB = {5'd31, 5'd23, 5'd15, 5'd9, 5'd7};
    localparam logic [4:0][4:0] TAP_TAB = {5'd28, 5'd18, 5'd14, 5'd5, 5'd6};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [2:0] mode_idx(input logic [2:0] m);
        case (m)
            MODE_PRBS7:  return 3'd0;
            MODE_PRBS9:  return 3'd1;
            MODE_PRBS15: return 3'd2;
            MODE_PRBS23: return 3'd3;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic [4:0] mode_deg(input logic [2:0] m);
        return DEG_TAB[mode_idx(m)];
    endfunction

    function automatic logic [4:0] mode_tap(input logic [2:0] m);
        return TAP_TAB[mode_idx(m)];
    endfunction

    // All-ones mask covering the low deg bits of the LFSR register.
    function automatic logic [LFSR_W-1:0] len_mask(input logic [4:0] deg);
        return 31'h7FFF_FFFF >> (5'd31 - deg);
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational DATA_W-step Fibonacci LFSR advance: next state plus the DATA_W output bits.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_mode,
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_state,
    output logic [DATA_W-1:0] o_word
);

    logic [4:0]        w_deg;
    logic [4:0]        w_tap;
    logic [LFSR_W-1:0] w_mask;
    logic [LFSR_W-1:0] w_s;
    logic              w_ob;
    logic              w_fb;

    // Unrolled shift: the oldest bit leaves first and lands in the word MSB.
    always_comb begin
        w_deg  = mode_deg(i_mode);
        w_tap  = mode_tap(i_mode);
        w_mask = len_mask(w_deg);
        w_s    = i_state;
        w_ob   = 1'b0;
        w_fb   = 1'b0;
        o_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_ob = w_s[w_deg - 5'd1];
            w_fb = w_ob ^ w_s[w_tap - 5'd1];
            o_word[DATA_W-1-i] = w_ob;
            w_s = ((w_s << 1) | {{(LFSR_W-1){1'b0}}, w_fb}) & w_mask;
        end
        o_state = w_s;
    end

endmodule

// File: rtl/prbs_gen_param.sv
// Parameterised PRBS7/9/15/23/31 word generator with seed load, error injection and accepted-word count.
// Latency: first word valid two edges after Load (Load edge, then FILL edge with Enable); then one word per cycle.
// Backpressure: valid/ready; word and LFSR hold while Out_Valid=1 and Out_Ready=0.
module prbs_gen_param
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [2:0]        Mode,
    input  logic [30:0]       Seed,
    input  logic              Enable,
    input  logic              Err_Inject,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Seed_Zero,
    output logic [CNT_W-1:0]  Word_Cnt
);

    state_t            r_state;
    logic [2:0]        r_mode;
    logic [LFSR_W-1:0] r_lfsr;
    logic              r_err_pend;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_seed_zero;
    logic [CNT_W-1:0]  r_cnt;

    logic [LFSR_W-1:0] w_seed_fill;
    logic [LFSR_W-1:0] w_seed_masked;
    logic [LFSR_W-1:0] w_step_state;
    logic [DATA_W-1:0] w_step_word;
    logic [DATA_W-1:0] w_err_mask;
    logic [DATA_W-1:0] w_word_out;
    logic              w_accept;
    logic              w_gen;

    prbs_lfsr_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_mode  (r_mode),
        .i_state (r_lfsr),
        .o_state (w_step_state),
        .o_word  (w_step_word)
    );

    // Seed masking uses the incoming Mode since it is latched on the same edge.
    assign w_seed_fill   = len_mask(mode_deg(Mode));
    assign w_seed_masked = Seed & w_seed_fill;

    assign w_accept = r_valid & Out_Ready;
    assign w_gen    = Enable & ((r_state == ST_FILL) | ((r_state == ST_RUN) & w_accept));

    // A pending or same-cycle error flips only the oldest bit of the word being generated.
    always_comb begin
        w_err_mask             = '0;
        w_err_mask[DATA_W-1]   = r_err_pend | Err_Inject;
        w_word_out             = w_step_word ^ w_err_mask;
    end

    // Control FSM with registered outputs; Reset beats Load, Load beats everything else.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_PRBS31;
            r_lfsr      <= {LFSR_W{1'b1}};
            r_err_pend  <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_seed_zero <= 1'b0;
            r_cnt       <= '0;
        end else if (Load) begin
            r_state     <= ST_FILL;
            r_mode      <= Mode;
            r_lfsr      <= (w_seed_masked == '0) ? w_seed_fill : w_seed_masked;
            r_err_pend  <= 1'b0;
            r_valid     <= 1'b0;
            r_seed_zero <= (w_seed_masked == '0);
            r_cnt       <= '0;
        end else begin
            r_seed_zero <= 1'b0;
            if (w_gen) begin
                r_err_pend <= 1'b0;
            end else if (Err_Inject) begin
                r_err_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                end
                ST_FILL: begin
                    if (Enable) begin
                        r_data  <= w_word_out;
                        r_lfsr  <= w_step_state;
                        r_valid <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (Enable) begin
                            r_data <= w_word_out;
                            r_lfsr <= w_step_state;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ST_FILL;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Out_Data  = r_data;
    assign Out_Valid = r_valid;
    assign Seed_Zero = r_seed_zero;
    assign Word_Cnt  = r_cnt;

endmodule

// File: tb/tb_prbs_gen_param.sv
// Bench for prbs_gen_param: first-word vector table, period checks, corner sequences and random traffic.
// Reference: output bit stream built from the recurrence b[n] = b[n-L] ^ b[n-T] seeded MSB-first.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_prbs_gen_param;

    localparam int DW = 8;
    localparam int CW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Load;
    logic [2:0]    Mode;
    logic [30:0]   Seed;
    logic          Enable;
    logic          Err_Inject;
    logic [DW-1:0] Out_Data;
    logic          Out_Valid;
    logic          Out_Ready;
    logic          Seed_Zero;
    logic [CW-1:0] Word_Cnt;

    always #5 Clk = ~Clk;

    prbs_gen_param #(.DATA_W(DW), .CNT_W(CW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load       (Load),
        .Mode       (Mode),
        .Seed       (Seed),
        .Enable     (Enable),
        .Err_Inject (Err_Inject),
        .Out_Data   (Out_Data),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Seed_Zero  (Seed_Zero),
        .Word_Cnt   (Word_Cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    bit            mb[$];
    int            mL, mT, mwidx;
    int            mst;            // 0 idle, 1 waiting for enable, 2 streaming
    bit            mvalid, mpend, mzero;
    logic [DW-1:0] mdata;
    logic [CW-1:0] mcnt;
    logic [DW-1:0] acc_q[$];

    task automatic get_word(input int k, output logic [DW-1:0] w);
        while (mb.size() < (k + 1) * DW) begin
            int n = mb.size();
            mb.push_back(mb[n - mL] ^ mb[n - mT]);
        end
        for (int i = 0; i < DW; i++) w[DW-1-i] = mb[k * DW + i];
    endtask

    task automatic model_load(input logic [2:0] md, input logic [30:0] sd);
        logic [63:0] ms;
        case (md)
            3'd0:    begin mL = 7;  mT = 6;  end
            3'd1:    begin mL = 9;  mT = 5;  end
            3'd2:    begin mL = 15; mT = 14; end
            3'd3:    begin mL = 23; mT = 18; end
            default: begin mL = 31; mT = 28; end
        endcase
        ms    = {33'b0, sd} & ((64'd1 << mL) - 64'd1);
        mzero = (ms == 64'd0);
        if (mzero) ms = (64'd1 << mL) - 64'd1;
        mb.delete();
        for (int i = 0; i < mL; i++) mb.push_back(ms[mL-1-i]);
        mwidx  = 0;
        mvalid = 1'b0;
        mst    = 1;
        mcnt   = '0;
        mpend  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, take the edge, compare everything.
    task automatic cyc(input bit rst, input bit ld, input logic [2:0] md, input logic [30:0] sd,
                       input bit en, input bit rdy, input bit err);
        logic [DW-1:0] w;
        bit acc, gen;
        Reset = rst; Load = ld; Mode = md; Seed = sd;
        Enable = en; Out_Ready = rdy; Err_Inject = err;
        if (!rst && !ld && Out_Valid && rdy) acc_q.push_back(Out_Data);
        if (rst) begin
            mst = 0; mvalid = 0; mdata = '0; mcnt = '0; mpend = 0; mzero = 0;
        end else if (ld) begin
            model_load(md, sd);
        end else begin
            mzero = 0;
            acc = (mst == 2) && mvalid && rdy;
            gen = en && ((mst == 1) || acc);
            if (acc) mcnt = mcnt + 1;
            if (acc && !en) begin mvalid = 0; mst = 1; end
            if (gen) begin
                get_word(mwidx, w);
                mwidx++;
                if (mpend || err) w[DW-1] = ~w[DW-1];
                mpend = 0; mdata = w; mvalid = 1; mst = 2;
            end else begin
                mpend = mpend | err;
            end
        end
        @(posedge Clk);
        #1;
        check("cycle{vld,sz,cnt,dat}", {22'b0, Out_Valid, Seed_Zero, Word_Cnt, Out_Data},
              {22'b0, mvalid, mzero, mcnt, mdata});
    endtask

    task automatic run(input int n, input bit en, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 31'd0, en, rdy, 0);
    endtask

    typedef struct {
        logic [2:0]    mode;
        logic [30:0]   seed;
        logic [DW-1:0] word;
        logic          zero;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [DW-1:0] wexp;
        logic [DW-1:0] hold_d;
        logic [CW-1:0] hold_c;

        tbl[0] = '{3'd0, 31'h7F,       8'hFE, 1'b0};
        tbl[1] = '{3'd0, 31'h00,       8'hFE, 1'b1};
        tbl[2] = '{3'd0, 31'h01,       8'h02, 1'b0};
        tbl[3] = '{3'd0, 31'h80,       8'hFE, 1'b1};
        tbl[4] = '{3'd1, 31'h200,      8'hFF, 1'b1};
        tbl[5] = '{3'd2, 31'h1234,     8'h24, 1'b0};
        tbl[6] = '{3'd3, 31'h7FABCDEF, 8'h57, 1'b0};
        tbl[7] = '{3'd6, 31'h40000000, 8'h80, 1'b0};
        tbl[8] = '{3'd7, 31'h0,        8'hFF, 1'b1};

        Reset = 1; Load = 0; Mode = 0; Seed = 0; Enable = 0; Out_Ready = 0; Err_Inject = 0;
        mst = 0; mvalid = 0; mdata = '0; mcnt = '0; mpend = 0; mzero = 0; mL = 31; mT = 28; mwidx = 0;

        // Reset state, then IDLE must ignore Enable
        cyc(1, 0, 3'd0, 31'd0, 1, 1, 0);
        cyc(1, 1, 3'd0, 31'h7F, 1, 1, 0);
        check("reset_valid", Out_Valid, 0);
        check("reset_data", Out_Data, 0);
        check("reset_cnt", Word_Cnt, 0);
        check("reset_seed_zero", Seed_Zero, 0);
        run(3, 1, 1);
        check("idle_ignores_enable", Out_Valid, 0);

        // First-word table: Load edge, then one FILL edge
        foreach (tbl[i]) begin
            cyc(0, 1, tbl[i].mode, tbl[i].seed, 1, 0, 0);
            check($sformatf("tbl%0d_seed_zero", i), Seed_Zero, tbl[i].zero);
            check($sformatf("tbl%0d_valid_early", i), Out_Valid, 0);
            run(1, 1, 0);
            check($sformatf("tbl%0d_valid", i), Out_Valid, 1);
            check($sformatf("tbl%0d_word", i), Out_Data, tbl[i].word);
            run(1, 1, 0);
            check($sformatf("tbl%0d_seed_zero_gone", i), Seed_Zero, 0);
        end

        // Full period for PRBS7/9/15 from an all-ones seed
        for (int m = 0; m < 3; m++) begin
            int p, run_z, max_z, lw;
            lw = (m == 0) ? 7 : (m == 1) ? 9 : 15;
            p  = (1 << lw) - 1;
            cyc(0, 1, 3'(m), 31'h7FFFFFFF, 1, 1, 0);
            acc_q.delete();
            run(p + 3, 1, 1);
            check($sformatf("period_len_m%0d", m), acc_q.size() > p, 1);
            if (acc_q.size() > p) begin
                check($sformatf("period_wrap_m%0d", m), acc_q[p], acc_q[0]);
                run_z = 0; max_z = 0;
                for (int k = 0; k <= p; k++)
                    for (int b = DW - 1; b >= 0; b--) begin
                        if (acc_q[k][b]) run_z = 0;
                        else begin run_z++; if (run_z > max_z) max_z = run_z; end
                    end
                check($sformatf("max_zero_run_m%0d", m), max_z, lw - 1);
            end
        end

        // Ready stall mid-stream
        cyc(0, 1, 3'd1, 31'h0A5, 1, 1, 0);
        run(6, 1, 1);
        hold_d = Out_Data; hold_c = Word_Cnt;
        for (int i = 0; i < 5; i++) begin
            run(1, 1, 0);
            check("stall_data", Out_Data, hold_d);
            check("stall_cnt", Word_Cnt, hold_c);
        end
        run(6, 1, 1);
        check("resume_cnt", Word_Cnt, hold_c + 6);

        // Error injection: streaming, while stalled, and while enable is low
        cyc(0, 1, 3'd2, 31'h1ACE, 1, 1, 0);
        run(4, 1, 1);
        cyc(0, 0, 3'd0, 31'd0, 1, 1, 1);
        run(6, 1, 1);
        cyc(0, 0, 3'd0, 31'd0, 1, 0, 1);
        run(3, 1, 0);
        run(4, 1, 1);
        run(2, 0, 1);
        cyc(0, 0, 3'd0, 31'd0, 0, 1, 1);
        run(4, 1, 1);

        // Reset mid-run, reload with the same seed
        cyc(0, 1, 3'd3, 31'h123456, 1, 1, 0);
        get_word(0, wexp);
        run(1, 1, 1);
        check("first_word_before_reset", Out_Data, wexp);
        run(5, 1, 1);
        cyc(1, 0, 3'd0, 31'd0, 1, 1, 0);
        check("midrun_reset_valid", Out_Valid, 0);
        cyc(0, 1, 3'd3, 31'h123456, 1, 1, 0);
        run(1, 1, 1);
        check("first_word_after_reset", Out_Data, wexp);

        // Load while stalled, and Load coincident with an accept
        run(3, 1, 1);
        run(2, 1, 0);
        cyc(0, 1, 3'd0, 31'h55, 1, 0, 0);
        check("load_in_stall_cnt", Word_Cnt, 0);
        run(3, 1, 1);
        cyc(0, 1, 3'd0, 31'h55, 1, 1, 0);
        check("load_beats_accept_cnt", Word_Cnt, 0);
        check("load_beats_accept_vld", Out_Valid, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst, ld;
            logic [30:0] sd;
            rst = ($urandom_range(399) == 0);
            ld  = ($urandom_range(59) == 0);
            sd  = ($urandom_range(7) == 0) ? 31'd0 : 31'($urandom);
            cyc(rst, ld, 3'($urandom_range(7)), sd,
                $urandom_range(9) < 8, $urandom_range(9) < 7, $urandom_range(24) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
